// File: rtl/apb3s_pkg.sv
// rtl/apb3s_pkg.sv - shared types, widths and address helper for the apb3s completer.
package apb3_pkg;

  typedef enum logic [0:0] {ST_IDLE, ST_ACCESS} apb3s_state_t;

  localparam int APB3_DW = 32;
  localparam int APB3_AW = 32;

  // Word index of a byte address, wrapped to the array depth (depth is a power of 2).
  function automatic logic [APB3_AW-1:0] apb3_word_idx(input logic [APB3_AW-1:0] addr,
                                                      input int unsigned depth);
    return (addr >> 2) & APB3_AW'(depth - 32'd1);
  endfunction

endpackage

// File: rtl/apb3s_if.sv
// rtl/apb3s_if.sv - APB3 bus bundle with initiator (master) and completer (slave) views.
interface apb3s_if;
  import apb3_pkg::*;

  logic               psel;
  logic               penable;
  logic               pwrite;
  logic [APB3_AW-1:0] paddr;
  logic [APB3_DW-1:0] pwdata;
  logic [APB3_DW-1:0] prdata;
  logic               pready;
  logic               pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb3s_mem.sv
// rtl/apb3s_mem.sv - word array: one synchronous write port, one combinational read port, async clear.
module apb3s_mem
  import apb3_pkg::*;
#(
  parameter int prm_DEPTH = 64,
  parameter int IW        = 6
) (
  input  logic               pclk,
  input  logic               presetn,
  input  logic               we,
  input  logic [IW-1:0]      waddr,
  input  logic [APB3_DW-1:0] wdata,
  input  logic [IW-1:0]      raddr,
  output logic [APB3_DW-1:0] rdata
);

  logic [APB3_DW-1:0] mem_q [prm_DEPTH];

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < prm_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb3s.sv
// rtl/apb3s.sv - APB3 completer memory model with fixed wait states; APB3S_PSLVERR_EN drives pslverr.
module apb3s
  import apb3_pkg::*;
#(
  parameter int prm_DEPTH = 64,
  parameter int prm_WAIT  = 0
) (
  input  logic     pclk,
  input  logic     presetn,
  apb3s_if.slave   bus
);

  localparam int                 IW       = (prm_DEPTH > 1) ? $clog2(prm_DEPTH) : 1;
  localparam logic [APB3_AW-1:0] ADDR_LIM = APB3_AW'(4 * prm_DEPTH);
  localparam logic [3:0]         WAIT4    = 4'(prm_WAIT);
`ifdef APB3S_PSLVERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  apb3s_state_t       state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               pready_q, pready_d;
  logic               pslverr_q, pslverr_d;
  logic [APB3_DW-1:0] prdata_q, prdata_d;
  logic               write_q, write_d;
  logic               err_q, err_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [APB3_DW-1:0] wdata_q, wdata_d;

  logic               setup_err;
  logic [IW-1:0]      setup_idx;
  logic               mem_we;
  logic [APB3_DW-1:0] mem_rdata;

  assign setup_err = (bus.paddr[1:0] != 2'b00) || (bus.paddr >= ADDR_LIM);
  assign setup_idx = IW'(apb3_word_idx(bus.paddr, unsigned'(prm_DEPTH)));

  apb3s_mem #(
    .prm_DEPTH (prm_DEPTH),
    .IW        (IW)
  ) u_mem (
    .pclk    (pclk),
    .presetn (presetn),
    .we      (mem_we),
    .waddr   (idx_q),
    .wdata   (wdata_q),
    .raddr   (setup_idx),
    .rdata   (mem_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    write_d   = write_q;
    err_d     = err_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    mem_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.psel && !bus.penable) begin
          state_d  = ST_ACCESS;
          write_d  = bus.pwrite;
          idx_d    = setup_idx;
          wdata_d  = bus.pwdata;
          err_d    = setup_err;
          cnt_d    = WAIT4;
          // Read data is captured here, so it reflects memory before any later write.
          prdata_d = (!bus.pwrite && !setup_err) ? mem_rdata : '0;
          if (WAIT4 == 4'd0) begin
            pready_d  = 1'b1;
            pslverr_d = setup_err && ERR_EN;
          end
        end
      end
      ST_ACCESS: begin
        if (!bus.psel) begin
          state_d   = ST_IDLE;
          cnt_d     = 4'd0;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end else if (pready_q) begin
          if (bus.penable) begin
            mem_we    = write_q && !err_q;
            state_d   = ST_IDLE;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
          end
        end else if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          cnt_d     = 4'd0;
          pready_d  = 1'b1;
          pslverr_d = err_q && ERR_EN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      write_q   <= write_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
    end
  end

  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;

endmodule
